// File: rtl/alu_result_logger.sv
// Captures ALU results {s, cout, f} into a FIFO for a downstream reader.
// Optional macro ALU_LOG_TIMESTAMP_EN stores a 16-bit cycle stamp with each entry (rd_ts).
module alu_result_logger #(
  parameter int unsigned DEPTH       = 8,
  parameter bit          CHANGE_ONLY = 1'b1,
  parameter int unsigned OVF_W       = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               f,
  input  logic                     cout,
  input  logic [1:0]               s,
  input  logic                     cap_en,
  input  logic                     clr,
  input  logic                     rd_en,
  output logic [10:0]              rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [OVF_W-1:0]         ovf_cnt
`ifdef ALU_LOG_TIMESTAMP_EN
  ,
  output logic [15:0]              rd_ts
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef ALU_LOG_TIMESTAMP_EN
  localparam int unsigned EW = 27;
`else
  localparam int unsigned EW = 11;
`endif

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [10:0]   r_last;
  logic          r_last_vld;
  logic [10:0]   r_rd_data;
  logic          r_rd_valid;
  logic [OVF_W-1:0] r_ovf;

  logic [10:0]   w_sample;
  logic [EW-1:0] w_entry;
  logic          w_empty;
  logic          w_full;
  logic          w_cap_req;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic          w_drop;

`ifdef ALU_LOG_TIMESTAMP_EN
  logic [15:0] r_ts_cnt;
  logic [15:0] r_rd_ts;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_ts_cnt <= '0;
    else        r_ts_cnt <= r_ts_cnt + 16'd1;
  end

  assign w_entry = {r_ts_cnt, w_sample};
  assign rd_ts   = r_rd_ts;
`else
  assign w_entry = w_sample;
`endif

  assign w_sample = {s, cout, f};
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));

  // A full FIFO being read this cycle frees the slot the write needs;
  // an empty FIFO has nothing to read, so the write never bypasses to rd_data.
  always_comb begin
    w_cap_req = cap_en && (!CHANGE_ONLY || !r_last_vld || (w_sample != r_last));
    w_rd_ok   = rd_en && !w_empty;
    w_wr_ok   = w_cap_req && (!w_full || w_rd_ok);
    w_drop    = w_cap_req && w_full && !w_rd_ok;
  end

  always_ff @(posedge clock) begin
    if (!clr && w_wr_ok) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= '0;
`ifdef ALU_LOG_TIMESTAMP_EN
      r_rd_ts    <= '0;
`endif
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_last_vld <= 1'b0;
      r_rd_valid <= 1'b0;
      r_ovf      <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rptr][10:0];
`ifdef ALU_LOG_TIMESTAMP_EN
        r_rd_ts   <= r_mem[r_rptr][26:11];
`endif
        r_rptr    <= r_rptr + 1'b1;
      end
      if (w_wr_ok) begin
        r_wptr     <= r_wptr + 1'b1;
        r_last     <= w_sample;
        r_last_vld <= 1'b1;
      end
      if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign ovf_cnt  = r_ovf;

endmodule

// File: tb/tb_alu_result_logger.sv
// Bench for alu_result_logger: two instances (log-every-cycle and change-only)
// checked each cycle against a queue-based model, plus directed literal checks.
module tb_alu_result_logger;

  localparam int unsigned DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] f = '0;
  logic       cout = 1'b0;
  logic [1:0] s = '0;
  logic       cap_en = 1'b0;
  logic       clr = 1'b0;
  logic       rd_en = 1'b0;

  logic [10:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, empty0, empty1, full0, full1;
  logic [3:0]  count0, count1;
  logic [7:0]  ovf0, ovf1;
`ifdef ALU_LOG_TIMESTAMP_EN
  logic [15:0] rd_ts0, rd_ts1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  alu_result_logger #(.DEPTH(DEPTH), .CHANGE_ONLY(1'b0), .OVF_W(8)) u0 (
    .clock(clock), .reset(reset), .f(f), .cout(cout), .s(s), .cap_en(cap_en),
    .clr(clr), .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .empty(empty0), .full(full0), .count(count0), .ovf_cnt(ovf0)
`ifdef ALU_LOG_TIMESTAMP_EN
    , .rd_ts(rd_ts0)
`endif
  );

  alu_result_logger #(.DEPTH(DEPTH), .CHANGE_ONLY(1'b1), .OVF_W(8)) u1 (
    .clock(clock), .reset(reset), .f(f), .cout(cout), .s(s), .cap_en(cap_en),
    .clr(clr), .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .empty(empty1), .full(full1), .count(count1), .ovf_cnt(ovf1)
`ifdef ALU_LOG_TIMESTAMP_EN
    , .rd_ts(rd_ts1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Model: instance 0 logs every enabled cycle, instance 1 only on change.
  int unsigned mq  [2][$];
  int unsigned mts [2][$];
  int unsigned m_last [2];
  bit          m_lv   [2];
  int unsigned m_ovf  [2];
  int unsigned m_rd   [2];
  int unsigned m_rts  [2];
  bit          m_rv   [2];
  int unsigned m_cyc;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_last[i] = 0; m_lv[i] = 0; m_ovf[i] = 0; m_rd[i] = 0; m_rts[i] = 0; m_rv[i] = 0;
    end
    m_cyc = 0;
    forever begin
      int unsigned samp;
      bit req;
      @(posedge clock or negedge reset);
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          mq[i].delete(); mts[i].delete();
          m_lv[i] = 0; m_ovf[i] = 0; m_rd[i] = 0; m_rts[i] = 0; m_rv[i] = 0;
        end
        m_cyc = 0;
      end else begin
        samp = (int'(s) * 512) + (int'(cout) * 256) + int'(f);
        for (int i = 0; i < 2; i++) begin
          if (clr) begin
            mq[i].delete(); mts[i].delete();
            m_ovf[i] = 0; m_lv[i] = 0; m_rv[i] = 0;
          end else begin
            req = cap_en && (i == 0 || !m_lv[i] || samp != m_last[i]);
            m_rv[i] = 0;
            if (rd_en && mq[i].size() > 0) begin
              m_rd[i]  = mq[i].pop_front();
              m_rts[i] = mts[i].pop_front();
              m_rv[i]  = 1;
            end
            if (req) begin
              if (mq[i].size() < DEPTH) begin
                mq[i].push_back(samp);
                mts[i].push_back(m_cyc);
                m_last[i] = samp;
                m_lv[i] = 1;
              end else if (m_ovf[i] < 255) begin
                m_ovf[i]++;
              end
            end
          end
        end
        m_cyc = (m_cyc + 1) % 65536;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("u0_count", count0, mq[0].size());
      chk("u0_empty", empty0, mq[0].size() == 0);
      chk("u0_full", full0, mq[0].size() == DEPTH);
      chk("u0_rd_valid", rd_valid0, m_rv[0]);
      chk("u0_rd_data", rd_data0, m_rd[0]);
      chk("u0_ovf", ovf0, m_ovf[0]);
      chk("u1_count", count1, mq[1].size());
      chk("u1_empty", empty1, mq[1].size() == 0);
      chk("u1_full", full1, mq[1].size() == DEPTH);
      chk("u1_rd_valid", rd_valid1, m_rv[1]);
      chk("u1_rd_data", rd_data1, m_rd[1]);
      chk("u1_ovf", ovf1, m_ovf[1]);
`ifdef ALU_LOG_TIMESTAMP_EN
      chk("u0_rd_ts", rd_ts0, m_rts[0]);
      chk("u1_rd_ts", rd_ts1, m_rts[1]);
`endif
    end
  end

  initial begin
    int unsigned got [$];
    tick(3);
    reset = 1'b1;
    tick();
    chk("rst_empty", empty0, 1);
    chk("rst_count", count0, 0);
    chk("rst_full", full0, 0);
    chk("rst_rd_data", rd_data0, 0);
    chk("rst_rd_valid", rd_valid0, 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("empty_pop_valid", rd_valid0, 0);
    chk("empty_pop_data", rd_data0, 0);

    // Held value logs once in change-only mode, then the new value logs.
    s = 2'b01; f = 8'd50; cout = 1'b0; cap_en = 1'b1;
    tick(10);
    f = 8'd55;
    tick();
    cap_en = 1'b0;
    chk("co_count", count1, 2);
    rd_en = 1'b1; tick();
    chk("co_pop1_valid", rd_valid1, 1);
    chk("co_pop1_data", rd_data1, 11'h232);
    tick(); rd_en = 1'b0;
    chk("co_pop2_valid", rd_valid1, 1);
    chk("co_pop2_data", rd_data1, 11'h237);
    tick();
    chk("co_idle_valid", rd_valid1, 0);
    clr = 1'b1; tick(); clr = 1'b0;

    // Log every cycle until full, then overflow.
    s = 2'b10; f = 8'hA5; cout = 1'b1; cap_en = 1'b1;
    tick(8);
    chk("fill_full", full0, 1);
    tick(4);
    chk("fill_ovf", ovf0, 4);
    rd_en = 1'b1; tick();
    chk("full_rw_count", count0, 8);
    chk("full_rw_ovf", ovf0, 4);
    cap_en = 1'b0;
    tick(5); rd_en = 1'b0;
    chk("three_left", count0, 3);
    clr = 1'b1; rd_en = 1'b1; tick(); clr = 1'b0; rd_en = 1'b0;
    chk("clr_empty", empty0, 1);
    chk("clr_ovf", ovf0, 0);
    chk("clr_rd_valid", rd_valid0, 0);

    // Twenty distinct values across pointer wrap with interleaved pops.
    s = 2'b10; cout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      f = 8'(i); cap_en = 1'b1; rd_en = (i % 3 != 0);
      tick();
      if (rd_valid1) got.push_back(int'(rd_data1));
    end
    cap_en = 1'b0; rd_en = 1'b1;
    for (int k = 0; k < 30 && got.size() < 20; k++) begin
      tick();
      if (rd_valid1) got.push_back(int'(rd_data1));
    end
    rd_en = 1'b0;
    chk("stream_len", got.size(), 20);
    for (int k = 0; k < 20 && k < got.size(); k++)
      chk($sformatf("stream_%0d", k), got[k], 32'h500 + k);
    tick();

    // Asynchronous reset mid-stream.
    clr = 1'b1; tick(); clr = 1'b0;
    cap_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      f = 8'(100 + k);
      tick();
    end
    cap_en = 1'b0;
    chk("pre_reset_count", count0, 5);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_count", count0, 0);
    chk("async_rst_empty", empty0, 1);
    chk("async_rst_count1", count1, 0);
    tick();
    reset = 1'b1;
    tick();

`ifdef ALU_LOG_TIMESTAMP_EN
    begin
      logic [15:0] t_a, t_b;
      f = 8'd1; cap_en = 1'b1; tick(); cap_en = 1'b0;
      tick(5);
      f = 8'd2; cap_en = 1'b1; tick(); cap_en = 1'b0;
      rd_en = 1'b1; tick(); t_a = rd_ts0;
      tick(); t_b = rd_ts0; rd_en = 1'b0;
      chk("ts_delta", 32'(t_b - t_a), 6);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_logger.md
Name: alu_result_logger

Overview:
- Consumer end of the ALU datapath. Samples the ALU result bus (f, cout) together with the active op select s.
- Buffers distinct results in an on-chip FIFO for a downstream reader (debug UART, checker, or host port).
- Counterpart to the ALU stimulus driver: the driver writes operands and opcodes, this block captures and serves the results.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CHANGE_ONLY, 1, 1 = log only when {s,cout,f} differs from the last logged entry; 0 = log every enabled cycle.
- OVF_W, 8, width of the saturating overflow counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f  in  8  ALU result bus.
- cout  in  1  ALU carry out.
- s  in  2  ALU op select, stored as a tag.
- cap_en  in  1  capture enable.
- clr  in  1  synchronous flush.
- rd_en  in  1  pop request.
- rd_data  out  11  popped entry {s[1:0], cout, f[7:0]}.
- rd_valid  out  1  rd_data valid this cycle.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(DEPTH)+1  occupancy.
- ovf_cnt  out  OVF_W  dropped-sample count, saturating.

Behaviour:
- Reset (reset=0, async):
  - Pointers = 0, count = 0, empty = 1, full = 0.
  - rd_data = 0, rd_valid = 0, ovf_cnt = 0.
  - last-logged register invalid.
- Sampling:
  - Inputs are sampled on the rising clock edge.
  - sample = {s, cout, f}.
- Capture request (cap_req):
  - Requires cap_en = 1.
  - CHANGE_ONLY = 0: every enabled cycle is a request.
  - CHANGE_ONLY = 1: request only when the last-logged register is invalid or sample != last-logged.
- Write:
  - cap_req and not full: store sample, advance write pointer, update last-logged and set it valid.
  - cap_req and full: drop the sample; ovf_cnt += 1, saturating at all-ones.
  - A dropped sample does not update last-logged, so the same value retries next cycle.
- Read:
  - rd_en and not empty: rd_data is registered from the head entry, the read pointer advances, and rd_valid = 1 the next cycle.
  - Latency is 1 cycle.
  - rd_en while empty: ignored; rd_valid = 0 next cycle and rd_data holds its last value.
- Simultaneous read and write:
  - When full: the read frees a slot and the write is accepted in the same cycle; count unchanged, no overflow.
  - When empty: the write is stored and the read is ignored (no bypass); count becomes 1.
  - Otherwise both occur and count is unchanged.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Flags:
  - full = (count == DEPTH), empty = (count == 0).
  - Both are derived from registered count, so they are valid in the same cycle as count.
- clr = 1 (synchronous, highest priority over rd_en and cap_req):
  - Empty the FIFO and clear ovf_cnt.
  - Invalidate last-logged.
  - rd_valid = 0 next cycle.
- cap_en falling does not invalidate last-logged. Re-enabling with an unchanged result therefore logs nothing when CHANGE_ONLY = 1.
- Reset asserted mid-operation: immediate return to reset state, all stored data lost.

Optional Feature:
- Macro: ALU_LOG_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running cycle counter, reset to 0, wraps at 65535 to 0.
  - The counter value is stored with each entry.
  - Extra output rd_ts (16 bits) is registered alongside rd_data with the same latency; reset value 0.
- Undefined: no counter, no rd_ts port, and FIFO width stays 11 bits.

Test Plan:
- Reset then release; cap_en=0; pulse rd_en -> empty=1, count=0, rd_valid stays 0, rd_data=0.
- CHANGE_ONLY=1, cap_en=1, s=01, f=50, cout=0, held for 10 cycles, then f=55 -> count=2; two pops return 0x232 then 0x237 (11-bit {s,cout,f}), each with rd_valid one cycle after rd_en.
- CHANGE_ONLY=0, cap_en=1, rd_en=0 for 12 cycles, DEPTH=8 -> full=1 after 8 cycles, ovf_cnt=4.
- Then rd_en=1 and cap_en=1 together for 1 cycle -> count stays 8, ovf_cnt unchanged.
- FIFO holds 3 entries, assert clr together with rd_en -> next cycle empty=1, ovf_cnt=0, rd_valid=0.
- Write and read 20 distinct values (f = 0..19) with interleaved pops -> every entry returns in order across pointer wrap, and no entry is lost or duplicated.
- Assert reset mid-stream with count=5 -> count=0 and empty=1 immediately, without waiting for a clock edge.
- With ALU_LOG_TIMESTAMP_EN defined, entries logged at cycles 3 and 9 -> rd_ts values differ by 6.
